// File: rtl/fir_pkg.sv
// fir_pkg: FIR constants, coefficients, FSM states and result reduction (saturating when FIR_SATURATE_EN is defined)
package fir_pkg;
  localparam int NTAPS = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W = 18;
  localparam int ADDR_W = 10;
  localparam logic signed [DATA_W-1:0] COEF [NTAPS] = '{8'sd16, 8'sd48, 8'sd48, 8'sd16};
  typedef enum logic [2:0] {IDLE, NP_ADDR, NP_MAC, NP_WRITE, P_RUN, P_DRAIN, DONE} state_t;
  function automatic logic [DATA_W-1:0] fir_reduce(input logic signed [ACC_W-1:0] acc);
`ifdef FIR_SATURATE_EN
    logic signed [ACC_W-1:0] s;
    s = acc >>> 7;
    return (s > 127) ? 8'h7f : (s < -128) ? 8'h80 : s[DATA_W-1:0];
`else
    return DATA_W'(acc >>> 7);
`endif
  endfunction
endpackage

// File: rtl/fir_dpram.sv
// fir_dpram: sample RAM with synchronous-read port A and write port B; addresses wrap modulo DEPTH
module fir_dpram
  import fir_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic [DATA_W-1:0] data_b
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic unused_hi;
  assign unused_hi = ^{addr_a[ADDR_W-1:AW], addr_b[ADDR_W-1:AW]};
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b[AW-1:0]] <= data_b;
    data_a <= mem[addr_a[AW-1:0]];
  end
endmodule

// File: rtl/fir_filter_top.sv
// fir_filter_top: RAM-backed FIR subsystem with multi-cycle and pipelined engines (FIR_SATURATE_EN selects saturation)
module fir_filter_top
  import fir_pkg::*;
#(
  parameter int INPUT_ADDR = 0,
  parameter int OUTPUT_ADDR = 32,
  parameter int SAMPLE_COUNT = 20,
  parameter int MEM_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_pipelined,
  output logic       done,
  output logic [2:0] cycle_count
);
  localparam int KW = $clog2(NTAPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SAMPLE_COUNT - 1);
  localparam logic [ADDR_W-1:0] IA = ADDR_W'(INPUT_ADDR);
  localparam logic [ADDR_W-1:0] OA = ADDR_W'(OUTPUT_ADDR);
  localparam logic [KW-1:0] KLAST = KW'(NTAPS - 1);
  state_t state, state_nx;
  logic start_q, accept, busy, sel_q, v1, v2;
  logic [31:0] cycle_counter;
  logic [ADDR_W-1:0] n, w;
  logic [KW-1:0] k;
  logic signed [ACC_W-1:0] acc, prod, mac_np, mac_p;
  logic signed [DATA_W-1:0] x_s;
  logic signed [DATA_W-1:0] dl [NTAPS-1];
  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic [DATA_W-1:0] mem_data_out_a, mem_data_in_b;
  logic mem_we_b;
  logic unused_bits;
  assign unused_bits = ^{cycle_counter[31:3], sel_q};
  assign busy = (state != IDLE) && (state != DONE);
  assign accept = start && !start_q && !busy;
  assign done = state == DONE;
  assign cycle_count = cycle_counter[2:0];
  fir_dpram #(.DEPTH(MEM_DEPTH)) u_ram (
    .clk(clk), .addr_a(mem_addr_a), .data_a(mem_data_out_a),
    .addr_b(mem_addr_b), .we_b(mem_we_b), .data_b(mem_data_in_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start_q <= 1'b0;
      cycle_counter <= '0;
    end else begin
      state <= state_nx;
      start_q <= start;
      cycle_counter <= accept ? '0 : busy ? cycle_counter + 1 : cycle_counter;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? (sel_pipelined ? P_RUN : NP_ADDR) : state;
      NP_ADDR:    state_nx = NP_MAC;
      NP_MAC:     state_nx = (k == KLAST) ? NP_WRITE : NP_ADDR;
      NP_WRITE:   state_nx = (n == LAST) ? DONE : NP_ADDR;
      P_RUN:      state_nx = (n == LAST) ? P_DRAIN : P_RUN;
      P_DRAIN:    state_nx = (v2 && w == LAST) ? DONE : P_DRAIN;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    mem_addr_a = (state == NP_ADDR) ? IA + n - ADDR_W'(k) : (state == P_RUN) ? IA + n : '0;
    mem_we_b = (state == NP_WRITE) || (v2 && (state == P_RUN || state == P_DRAIN));
    mem_addr_b = (state == NP_WRITE) ? OA + n : (state == P_RUN || state == P_DRAIN) ? OA + w : mem_addr_a;
    mem_data_in_b = fir_reduce(acc);
  end
  // taps reaching before sample 0 still take their cycles but contribute zero
  always_comb begin
    x_s = $signed(mem_data_out_a);
    prod = ACC_W'(COEF[k]) * ACC_W'(x_s);
    mac_np = acc + ((n >= ADDR_W'(k)) ? prod : '0);
    mac_p = ACC_W'(COEF[0]) * ACC_W'(x_s);
    for (int i = 1; i < NTAPS; i++) mac_p = mac_p + ACC_W'(COEF[i]) * ACC_W'(dl[i-1]);
  end
  always_ff @(posedge clk) begin
    if (rst) sel_q <= 1'b0;
    else if (accept) sel_q <= sel_pipelined;
  end
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      n <= '0;
      k <= '0;
      w <= '0;
      acc <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int i = 0; i < NTAPS - 1; i++) dl[i] <= '0;
    end else begin
      v1 <= state == P_RUN;
      v2 <= v1;
      if (state == NP_MAC) begin
        acc <= mac_np;
        k <= (k == KLAST) ? '0 : k + 1'b1;
      end
      if (state == NP_WRITE) begin
        acc <= '0;
        n <= n + 1'b1;
      end
      if (state == P_RUN) n <= n + 1'b1;
      if (v1) begin
        acc <= mac_p;
        dl[0] <= x_s;
        for (int i = 1; i < NTAPS - 1; i++) dl[i] <= dl[i-1];
      end
      if (v2) w <= w + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_filter_top.sv
// tb_fir_filter_top: directed runs of both engines with a write scoreboard and back-door RAM access
module tb_fir_filter_top;
  import fir_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel_pipelined = 1'b0;
  logic done;
  logic [2:0] cycle_count;
  int total = 0, bad = 0, cyc = 0;
  int xm [64];
  logic [13:0] sb [$];
  logic [13:0] e;
  localparam int C [4] = '{16, 48, 48, 16};
  localparam int SINV [10] = '{0, 10, 19, 29, 37, 45, 51, 57, 60, 63};
  localparam int IMP [5] = '{15, 47, 47, 15, 0};
  always #5 clk = ~clk;
  fir_filter_top dut (
    .clk(clk), .rst(rst), .start(start), .sel_pipelined(sel_pipelined),
    .done(done), .cycle_count(cycle_count)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] model(input int n);
    int a = 0;
    for (int k = 0; k < 4; k++) if (n - k >= 0) a += C[k] * xm[n-k];
    a = a >>> 7;
`ifdef FIR_SATURATE_EN
    a = (a > 127) ? 127 : (a < -128) ? -128 : a;
`endif
    return 8'(a);
  endfunction
  task automatic push_run();
    for (int n = 0; n < 20; n++) sb.push_back({6'((32 + n) % 64), model(n)});
  endtask
  task automatic wait_done(input int maxc);
    while (done !== 1'b1 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", 32'(done), 1);
  endtask
  always @(negedge clk) begin
    if (dut.mem_we_b === 1'b1) begin
      check("write_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(dut.mem_addr_b[5:0]), 32'(e[13:8]));
        check("wr_data", 32'(dut.mem_data_in_b), 32'(e[7:0]));
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 0);
    check("rst_cc", 32'(cycle_count), 0);
    check("rst_ctr", dut.cycle_counter, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      xm[i] = $rtoi($sin(6.283185307179586 * i / 40.0) * 64.0);
      dut.u_ram.mem[i] = 8'(xm[i]);
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) check("bd_read", 32'(dut.u_ram.mem[i]), SINV[i]);
    push_run();
    sel_pipelined = 1'b0;
    start = 1'b1;
    cyc = 0;
    wait_done(400);
    check("np_latency", cyc, 181);
    check("np_ctr", dut.cycle_counter, 180);
    check("np_cc", 32'(cycle_count), 4);
    repeat (5) @(negedge clk);
    check("np_hold_done", 32'(done), 1);
    check("np_hold_ctr", dut.cycle_counter, 180);
    start = 1'b0;
    @(negedge clk);
    check("np_sb_empty", sb.size(), 0);
    check("np_y0", 32'(dut.u_ram.mem[32]), 0);
    check("np_y1", 32'(dut.u_ram.mem[33]), 1);
    push_run();
    sel_pipelined = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("p_accept_done", 32'(done), 0);
    wait_done(100);
    check("p_latency", cyc, 23);
    check("p_ctr", dut.cycle_counter, 22);
    check("p_cc", 32'(cycle_count), 6);
    @(negedge clk);
    check("p_sb_empty", sb.size(), 0);
    for (int i = 0; i < 20; i++) check("p_vs_np", 32'(dut.u_ram.mem[32+i]), 32'(model(i)));
    for (int i = 0; i < 20; i++) begin
      xm[i] = (i == 0) ? 127 : 0;
      dut.u_ram.mem[i] = 8'(xm[i]);
    end
    push_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    wait_done(100);
    @(negedge clk);
    check("imp_sb_empty", sb.size(), 0);
    for (int i = 0; i < 5; i++) check("imp_y", 32'(dut.u_ram.mem[32+i]), IMP[i]);
    push_run();
    sel_pipelined = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("mid_done", 32'(done), 0);
    check("mid_ctr", dut.cycle_counter, 0);
    check("mid_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    push_run();
    sel_pipelined = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    wait_done(100);
    check("post_rst_ctr", dut.cycle_counter, 22);
    @(negedge clk);
    check("post_rst_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
